// File: rtl/mole_round_ctrl.sv
// mole_round_ctrl: LFSR mole pick, guess/timeout judging, score and miss tracking; define MOLE_NO_REPEAT_EN to forbid back-to-back repeated holes
module mole_round_ctrl #(
  parameter int unsigned ROUND_TICKS = 50000000,
  parameter int unsigned COOLDOWN_TICKS = 25000000,
  parameter int unsigned MAX_MISSES = 3,
  parameter logic [7:0] LFSR_SEED = 8'hA5
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_guess_valid,
  input  logic [2:0] i_guess,
  output logic [2:0] o_mole_position,
  output logic [2:0] o_user_guess,
  output logic       o_user_right,
  output logic       o_user_wrong,
  output logic       o_timeout,
  output logic [7:0] o_score,
  output logic [3:0] o_misses,
  output logic       o_game_over
);
  localparam int unsigned TMAX = ROUND_TICKS > COOLDOWN_TICKS ? ROUND_TICKS : COOLDOWN_TICKS;
  localparam int TW = $clog2(TMAX);
  localparam logic [7:0] SEED = LFSR_SEED == 8'h00 ? 8'h01 : LFSR_SEED;
  typedef enum logic [2:0] {IDLE, ARM, WAIT_GUESS, COOLDOWN, GAME_OVER} state_t;
  state_t state, state_nx;
  logic [7:0] lfsr;
  logic [TW-1:0] timer;
  logic [2:0] pick;
  logic [3:0] misses_inc;
  logic start_ok, judge, hit, tmo, miss, last_miss, cd_done, timer_run;
  assign start_ok   = i_start && (state == IDLE || state == GAME_OVER);
  assign judge      = state == WAIT_GUESS && i_guess_valid;
  assign hit        = i_guess == o_mole_position;
  assign tmo        = state == WAIT_GUESS && !i_guess_valid && timer == TW'(ROUND_TICKS - 1);
  assign miss       = (judge && !hit) || tmo;
  assign misses_inc = o_misses + 4'd1;
  assign last_miss  = misses_inc == 4'(MAX_MISSES);
  assign cd_done    = timer == TW'(COOLDOWN_TICKS - 1);
  assign timer_run  = (state == WAIT_GUESS && !(judge || tmo)) || (state == COOLDOWN && !cd_done);
`ifdef MOLE_NO_REPEAT_EN
  assign pick = lfsr[2:0] == o_mole_position ? lfsr[2:0] + 3'd1 : lfsr[2:0];
`else
  assign pick = lfsr[2:0];
`endif
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE, GAME_OVER: state_nx = start_ok ? ARM : state;
      ARM:             state_nx = WAIT_GUESS;
      WAIT_GUESS:      state_nx = (judge || tmo) ? ((miss && last_miss) ? GAME_OVER : COOLDOWN) : WAIT_GUESS;
      COOLDOWN:        state_nx = cd_done ? ARM : COOLDOWN;
      default:         state_nx = IDLE;
    endcase
  end
  always_comb o_game_over = state == GAME_OVER;
  always_ff @(posedge i_clk or posedge i_rst)
    if (i_rst) begin
      lfsr            <= SEED;
      timer           <= '0;
      o_mole_position <= '0;
      o_user_guess    <= '0;
      o_user_right    <= 1'b0;
      o_user_wrong    <= 1'b0;
      o_timeout       <= 1'b0;
      o_score         <= '0;
      o_misses        <= '0;
    end else begin
      lfsr         <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      timer        <= timer_run ? timer + TW'(1) : '0;
      o_user_right <= judge && hit;
      o_user_wrong <= miss;
      o_timeout    <= tmo;
      if (start_ok) begin
        o_score  <= '0;
        o_misses <= '0;
      end
      if (state == ARM) o_mole_position <= pick;
      if (judge) o_user_guess <= i_guess;
      if (judge && hit) o_score <= o_score + {7'd0, o_score != 8'hFF};
      if (miss) o_misses <= misses_inc;
    end
endmodule

// File: tb/tb_mole_round_ctrl.sv
// tb_mole_round_ctrl: directed vector table plus corner-case sequences for mole_round_ctrl
module tb_mole_round_ctrl;
  localparam int RT = 20, CT = 4, MM = 3;
  typedef struct {
    bit to;
    logic [2:0] off;
    bit r, w, t;
    logic [7:0] score;
    logic [3:0] misses;
    bit go;
  } vec_t;
  logic clk = 1'b0, rst = 1'b0, start = 1'b0, gv = 1'b0;
  logic [2:0] guess = '0, exp_mole = '0, exp_guess = '0, prev = '0;
  logic [2:0] mole, ug;
  logic right, wrong, tmo, go;
  logic [7:0] score, m_lfsr;
  logic [3:0] misses;
  int checks = 0, passed = 0;
  vec_t v [5];
  always #5 clk = ~clk;
  mole_round_ctrl #(.ROUND_TICKS(RT), .COOLDOWN_TICKS(CT), .MAX_MISSES(MM), .LFSR_SEED(8'hA5)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_guess_valid(gv), .i_guess(guess),
    .o_mole_position(mole), .o_user_guess(ug), .o_user_right(right), .o_user_wrong(wrong),
    .o_timeout(tmo), .o_score(score), .o_misses(misses), .o_game_over(go));
  always @(posedge clk or posedge rst)
    if (rst) m_lfsr <= 8'hA5;
    else m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
  endtask
  task automatic chk_pulses(input string name, input bit r, input bit w, input bit t);
    chk({name, "_right"}, right, r);
    chk({name, "_wrong"}, wrong, w);
    chk({name, "_timeout"}, tmo, t);
  endtask
  task automatic arm_and_wait();
    prev = exp_mole;
`ifdef MOLE_NO_REPEAT_EN
    exp_mole = m_lfsr[2:0] == prev ? m_lfsr[2:0] + 3'd1 : m_lfsr[2:0];
`else
    exp_mole = m_lfsr[2:0];
`endif
    @(negedge clk);
    chk("mole", mole, exp_mole);
`ifdef MOLE_NO_REPEAT_EN
    chk("no_repeat", mole != prev, 1);
`endif
  endtask
  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_score", score, 0);
    chk("start_misses", misses, 0);
    chk("start_game_over", go, 0);
    arm_and_wait();
  endtask
  task automatic cooldown();
    repeat (3) begin
      @(negedge clk);
      chk_pulses("cooldown", 0, 0, 0);
    end
    @(negedge clk);
    chk_pulses("arm", 0, 0, 0);
    arm_and_wait();
  endtask
  task automatic guess_round(input logic [2:0] off);
    exp_guess = exp_mole + off;
    guess = exp_guess;
    gv = 1'b1;
    @(negedge clk);
    gv = 1'b0;
  endtask
  task automatic timeout_round();
    repeat (19) @(negedge clk);
    chk_pulses("pre_timeout", 0, 0, 0);
    @(negedge clk);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    v[0] = '{to: 0, off: 3'd0, r: 1, w: 0, t: 0, score: 8'd1, misses: 4'd0, go: 0};
    v[1] = '{to: 0, off: 3'd1, r: 0, w: 1, t: 0, score: 8'd1, misses: 4'd1, go: 0};
    v[2] = '{to: 1, off: 3'd0, r: 0, w: 1, t: 1, score: 8'd1, misses: 4'd2, go: 0};
    v[3] = '{to: 0, off: 3'd0, r: 1, w: 0, t: 0, score: 8'd2, misses: 4'd2, go: 0};
    v[4] = '{to: 0, off: 3'd7, r: 0, w: 1, t: 0, score: 8'd2, misses: 4'd3, go: 1};
    #2 rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_mole", mole, 0);
    chk("rst_guess", ug, 0);
    chk_pulses("rst", 0, 0, 0);
    chk("rst_score", score, 0);
    chk("rst_misses", misses, 0);
    chk("rst_game_over", go, 0);
    @(negedge clk);
    do_start();
    for (int i = 0; i < 5; i++) begin
      if (v[i].to) timeout_round();
      else guess_round(v[i].off);
      chk_pulses($sformatf("row%0d", i), v[i].r, v[i].w, v[i].t);
      chk($sformatf("row%0d_guess", i), ug, exp_guess);
      chk($sformatf("row%0d_score", i), score, v[i].score);
      chk($sformatf("row%0d_misses", i), misses, v[i].misses);
      chk($sformatf("row%0d_game_over", i), go, v[i].go);
      if (!v[i].go) cooldown();
    end
    guess = exp_mole;
    gv = 1'b1;
    @(negedge clk);
    gv = 1'b0;
    chk_pulses("over_guess", 0, 0, 0);
    @(negedge clk);
    chk_pulses("over_guess2", 0, 0, 0);
    chk("over_mole", mole, exp_mole);
    chk("over_score", score, 2);
    chk("over_misses", misses, 3);
    chk("over_game_over", go, 1);
    do_start();
    for (int i = 1; i <= 3; i++) begin
      timeout_round();
      chk_pulses($sformatf("to%0d", i), 0, 1, 1);
      chk($sformatf("to%0d_guess", i), ug, exp_guess);
      chk($sformatf("to%0d_misses", i), misses, i);
      chk($sformatf("to%0d_game_over", i), go, i == 3);
      if (i < 3) cooldown();
    end
    do_start();
    repeat (19) @(negedge clk);
    exp_guess = exp_mole;
    guess = exp_guess;
    gv = 1'b1;
    @(negedge clk);
    gv = 1'b0;
    chk_pulses("edge_guess", 1, 0, 0);
    chk("edge_guess_val", ug, exp_guess);
    chk("edge_score", score, 1);
    chk("edge_misses", misses, 0);
    cooldown();
    repeat (5) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_mole", mole, 0);
    chk("midrst_guess", ug, 0);
    chk_pulses("midrst", 0, 0, 0);
    chk("midrst_score", score, 0);
    chk("midrst_misses", misses, 0);
    chk("midrst_game_over", go, 0);
    guess = 3'd0;
    gv = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk_pulses("in_rst", 0, 0, 0);
    end
    rst = 1'b0;
    exp_mole = '0;
    exp_guess = '0;
    @(negedge clk);
    gv = 1'b0;
    @(negedge clk);
    chk_pulses("idle_guess", 0, 0, 0);
    chk("idle_guess_val", ug, 0);
    do_start();
    for (int k = 0; k < 260; k++) begin
      guess_round(3'd0);
      chk("long_right", right, 1);
      cooldown();
    end
    chk("score_sat", score, 255);
    chk("long_misses", misses, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
